// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared types, sizes and channel-scan helper for the ADC frame scheduler
package adc_sched_pkg;
   localparam int NUM_CH   = 8;
   localparam int ADC_W    = 12;
   localparam int CH_IDX_W = 3;

   typedef enum logic [1:0] {IDLE, WAIT_TICK, EMIT} state_t;

   typedef struct packed {
      logic                hit;
      logic [CH_IDX_W-1:0] idx;
   } ch_sel_t;

   // Lowest enabled channel at or above 'from'; 'from' is one bit wider so NUM_CH means "none left".
   function automatic ch_sel_t next_ch(input logic [NUM_CH-1:0] mask, input logic [CH_IDX_W:0] from);
      ch_sel_t r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask[i] && i >= int'(from)) r = '{hit: 1'b1, idx: CH_IDX_W'(i)};
      return r;
   endfunction
endpackage

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: sample-rate divider, one-cycle tick every div_i cycles while enabled
module adc_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d;

   // Count 0..div-1, held at zero while disabled so each run starts aligned
   always_comb begin
      tick_o = en_i && cnt_q == div_i - DIV_W'(1);
      cnt_d  = (!en_i || tick_o) ? '0 : cnt_q + DIV_W'(1);
   end

   // Divider counter register
   always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: ticks, snapshots all ADC channels and streams enabled ones in frames.
// Optional ADC_SCHED_SIGNED_EN: output samples as offset-removed two's complement (MSB inverted).
module adc_frame_scheduler
   import adc_sched_pkg::*;
#(
   parameter int FRAME_LEN = 256,
   parameter int DIV_W     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_CH*ADC_W-1:0] ch_data_i,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic                    continuous_i,
   input  logic [NUM_CH-1:0]       ch_mask_i,
   input  logic [DIV_W-1:0]        div_i,
   output logic [ADC_W-1:0]        out_data_o,
   output logic [CH_IDX_W-1:0]     out_ch_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic                    out_last_o,
   output logic                    busy_o,
   output logic                    overrun_o
);
   localparam int CNT_W = $clog2(FRAME_LEN);

   state_t                  state_q, state_d;
   logic                    cont_q, stop_pend_q, overrun_q;
   logic [NUM_CH-1:0]       mask_q;
   logic [DIV_W-1:0]        div_q;
   logic [NUM_CH*ADC_W-1:0] snap_q;
   logic [CNT_W-1:0]        samp_q;
   logic [ADC_W-1:0]        out_data_q, raw, sample;
   logic [CH_IDX_W-1:0]     out_ch_q;
   logic                    out_valid_q, out_last_q;
   logic                    tick, accept, xfer, halt, frame_end, first_last, nxt_last;
   ch_sel_t                 first, nxt;

   adc_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (state_q != IDLE),
      .div_i  (div_q),
      .tick_o (tick)
   );

   assign accept     = state_q == IDLE && start_i && !stop_i && |ch_mask_i && div_i >= DIV_W'(2);
   assign xfer       = out_valid_q && out_ready_i;
   assign halt       = stop_i || stop_pend_q;
   assign frame_end  = samp_q == CNT_W'(FRAME_LEN - 1);
   assign first      = next_ch(mask_q, '0);
   assign nxt        = next_ch(mask_q, (CH_IDX_W+1)'(out_ch_q) + (CH_IDX_W+1)'(1));
   assign first_last = !next_ch(mask_q, (CH_IDX_W+1)'(first.idx) + (CH_IDX_W+1)'(1)).hit;
   assign nxt_last   = !next_ch(mask_q, (CH_IDX_W+1)'(nxt.idx) + (CH_IDX_W+1)'(1)).hit;
   assign raw        = state_q == EMIT ? snap_q[nxt.idx*ADC_W +: ADC_W] : ch_data_i[first.idx*ADC_W +: ADC_W];
`ifdef ADC_SCHED_SIGNED_EN
   assign sample     = {~raw[ADC_W-1], raw[ADC_W-2:0]};
`else
   assign sample     = raw;
`endif

   // State register
   always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;

   // Next state: stop beats tick in WAIT_TICK; in EMIT leave only on a transfer
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = accept ? WAIT_TICK : IDLE;
         WAIT_TICK: state_d = stop_i ? IDLE : tick ? EMIT : WAIT_TICK;
         EMIT:      state_d = !xfer ? EMIT : (halt || (!nxt.hit && out_last_q && !cont_q)) ? IDLE : nxt.hit ? EMIT : WAIT_TICK;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy_o      = state_q != IDLE;
      out_data_o  = out_data_q;
      out_ch_o    = out_ch_q;
      out_valid_o = out_valid_q;
      out_last_o  = out_last_q;
      overrun_o   = overrun_q;
   end

   // Config latch, snapshot, channel scan, sample count and output beat register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cont_q      <= 1'b0;
         mask_q      <= '0;
         div_q       <= '0;
         snap_q      <= '0;
         samp_q      <= '0;
         stop_pend_q <= 1'b0;
         overrun_q   <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         stop_pend_q <= state_q == EMIT && !xfer && halt;
         if (accept) begin
            cont_q    <= continuous_i;
            mask_q    <= ch_mask_i;
            div_q     <= div_i;
            overrun_q <= 1'b0;
            samp_q    <= '0;
         end
         if (state_q == WAIT_TICK && tick && !stop_i) begin
            snap_q      <= ch_data_i;
            out_valid_q <= 1'b1;
            out_ch_q    <= first.idx;
            out_data_q  <= sample;
            out_last_q  <= frame_end && first_last;
         end
         if (state_q == EMIT) begin
            overrun_q <= overrun_q | tick;
            if (xfer) begin
               out_valid_q <= nxt.hit && !halt;
               out_last_q  <= 1'b0;
               if (nxt.hit && !halt) begin
                  out_ch_q   <= nxt.idx;
                  out_data_q <= sample;
                  out_last_q <= frame_end && nxt_last;
               end else if (!nxt.hit) samp_q <= frame_end ? '0 : samp_q + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb_adc_frame_scheduler: directed self-checking bench for adc_frame_scheduler (FRAME_LEN=4)
module tb_adc_frame_scheduler;
   logic        clk = 0, rst = 1, start = 0, stop = 0, cont = 0, ready = 0;
   logic [95:0] ch_data = '0;
   logic [7:0]  mask = '0;
   logic [15:0] div = '0;
   logic [11:0] out_data;
   logic [2:0]  out_ch;
   logic        out_valid, out_last, busy, overrun;
   int          n_cmp = 0, n_err = 0;

   adc_frame_scheduler #(.FRAME_LEN(4), .DIV_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .ch_data_i(ch_data), .start_i(start), .stop_i(stop),
      .continuous_i(cont), .ch_mask_i(mask), .div_i(div), .out_data_o(out_data), .out_ch_o(out_ch),
      .out_valid_o(out_valid), .out_ready_i(ready), .out_last_o(out_last), .busy_o(busy), .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] exp_conv(input logic [11:0] v);
`ifdef ADC_SCHED_SIGNED_EN
      return v ^ 12'h800;
`else
      return v;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ch(input logic [11:0] base);
      for (int i = 0; i < 8; i++) ch_data[i*12 +: 12] = base + 12'(i);
   endtask

   task automatic pulse_start();
      start = 1;
      step();
      start = 0;
   endtask

   task automatic wait_valid(input string name);
      int c;
      c = 0;
      while (!out_valid && c < 50) begin
         step();
         c++;
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL %s_wait: out_valid=%b after %0d cycles, want 1", name, out_valid, c);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      step();
      step();
      rst = 0;
      n_cmp++;
      if ({out_valid, out_last, busy, overrun, out_ch, out_data} !== 18'd0) begin
         n_err++;
         $display("FAIL reset: valid=%b last=%b busy=%b ovr=%b ch=%0d data=%h, want all 0",
                  out_valid, out_last, busy, overrun, out_ch, out_data);
      end
   endtask

   task automatic test_single();
      int beats;
      beats = 0;
      load_ch(12'h0A0);
      mask = 8'h01; div = 10; cont = 0; ready = 1;
      pulse_start();
      for (int c = 1; c <= 60; c++) begin
         step();
         if (out_valid) begin
            beats++;
            n_cmp++;
            if (c != 10*beats || out_ch !== 3'd0 || out_data !== exp_conv(12'h0A0) || out_last !== (beats == 4)) begin
               n_err++;
               $display("FAIL single_beat%0d: cyc=%0d ch=%0d data=%h last=%b, want cyc=%0d ch=0 data=%h last=%b",
                        beats, c, out_ch, out_data, out_last, 10*beats, exp_conv(12'h0A0), beats == 4);
            end
         end
      end
      n_cmp++;
      if (beats != 4 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_end: beats=%0d busy=%b, want 4 and 0", beats, busy);
      end
   endtask

   task automatic test_multi();
      int j;
      logic [2:0] seq [4];
      seq = '{3'd0, 3'd2, 3'd5, 3'd7};
      j = 0;
      load_ch(12'h100);
      mask = 8'hA5; div = 6; cont = 0; ready = 1;
      pulse_start();
      for (int c = 1; c <= 40; c++) begin
         step();
         if (out_valid) begin
            n_cmp++;
            if (j > 15 || c != 6*(j/4+1) + j%4 || out_ch !== seq[j%4] ||
                out_data !== exp_conv(12'h100 + 12'(seq[j%4])) || out_last !== (j == 15)) begin
               n_err++;
               $display("FAIL multi_beat%0d: cyc=%0d ch=%0d data=%h last=%b, want cyc=%0d ch=%0d data=%h last=%b",
                        j, c, out_ch, out_data, out_last, 6*(j/4+1) + j%4, seq[j%4],
                        exp_conv(12'h100 + 12'(seq[j%4])), j == 15);
            end
            j++;
         end
      end
      n_cmp++;
      if (j != 16 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL multi_end: beats=%0d busy=%b, want 16 and 0", j, busy);
      end
   endtask

   task automatic test_backpressure();
      int beats, c;
      beats = 0;
      c = 0;
      load_ch(12'h200);
      mask = 8'hFF; div = 4; cont = 0; ready = 0;
      pulse_start();
      wait_valid("bp");
      for (int k = 0; k < 10; k++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== exp_conv(12'h200)) begin
            n_err++;
            $display("FAIL bp_hold%0d: valid=%b ch=%0d data=%h, want 1 0 %h", k, out_valid, out_ch, out_data, exp_conv(12'h200));
         end
      end
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_err++;
         $display("FAIL bp_overrun: overrun=%b, want 1", overrun);
      end
      ready = 1;
      while (busy && c < 400) begin
         if (out_valid) begin
            n_cmp++;
            if (out_ch !== 3'(beats % 8) || out_data !== exp_conv(12'h200 + 12'(beats % 8)) || out_last !== (beats == 31)) begin
               n_err++;
               $display("FAIL bp_beat%0d: ch=%0d data=%h last=%b, want ch=%0d data=%h last=%b", beats, out_ch, out_data,
                        out_last, beats % 8, exp_conv(12'h200 + 12'(beats % 8)), beats == 31);
            end
            beats++;
         end
         step();
         c++;
      end
      n_cmp++;
      if (beats != 32 || busy !== 1'b0 || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL bp_end: beats=%0d busy=%b overrun=%b, want 32 0 1", beats, busy, overrun);
      end
   endtask

   task automatic test_stop();
      int extra;
      extra = 0;
      load_ch(12'h300);
      mask = 8'h03; div = 5; cont = 1; ready = 0;
      pulse_start();
      n_cmp++;
      if (overrun !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL stop_start: overrun=%b busy=%b, want 0 1", overrun, busy);
      end
      wait_valid("stop");
      stop = 1;
      step();
      stop = 0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== exp_conv(12'h300)) begin
            n_err++;
            $display("FAIL stop_hold%0d: valid=%b ch=%0d data=%h, want 1 0 %h", k, out_valid, out_ch, out_data, exp_conv(12'h300));
         end
      end
      ready = 1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL stop_idle: valid=%b busy=%b, want 0 0", out_valid, busy);
      end
      for (int k = 0; k < 20; k++) begin
         step();
         if (out_valid) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_err++;
         $display("FAIL stop_extra: beats=%0d, want 0", extra);
      end
      mask = 8'h00;
      pulse_start();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_mask0: busy=%b, want 0", busy);
      end
      mask = 8'h03; div = 1;
      pulse_start();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_div1: busy=%b, want 0", busy);
      end
      div = 5; stop = 1;
      pulse_start();
      stop = 0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_with_stop: busy=%b, want 0", busy);
      end
      pulse_start();
      stop = 1;
      step();
      stop = 0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL stop_wait: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      load_ch(12'h400);
      mask = 8'hFF; div = 4; cont = 1; ready = 0;
      pulse_start();
      for (int k = 0; k < 12; k++) step();
      n_cmp++;
      if (out_valid !== 1'b1 || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_pre: valid=%b overrun=%b, want 1 1", out_valid, overrun);
      end
      rst = 1;
      step();
      rst = 0;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_post: valid=%b busy=%b overrun=%b last=%b, want 0 0 0 0", out_valid, busy, overrun, out_last);
      end
   endtask

   task automatic test_signed();
      int beats;
      logic [11:0] want [3];
`ifdef ADC_SCHED_SIGNED_EN
      want = '{12'h800, 12'h000, 12'h7FF};
`else
      want = '{12'h000, 12'h800, 12'hFFF};
`endif
      beats = 0;
      ch_data = '0;
      ch_data[11:0] = 12'h000;
      ch_data[23:12] = 12'h800;
      ch_data[35:24] = 12'hFFF;
      mask = 8'h07; div = 2; cont = 0; ready = 1;
      pulse_start();
      for (int c = 0; c < 100 && busy; c++) begin
         step();
         if (out_valid) begin
            n_cmp++;
            if (out_ch !== 3'(beats % 3) || out_data !== want[beats % 3]) begin
               n_err++;
               $display("FAIL signed_beat%0d: ch=%0d data=%h, want ch=%0d data=%h", beats, out_ch, out_data, beats % 3, want[beats % 3]);
            end
            beats++;
         end
      end
      n_cmp++;
      if (beats != 12 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL signed_end: beats=%0d busy=%b, want 12 0", beats, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_backpressure();
      test_stop();
      test_reset_mid();
      test_signed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
